// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM burst arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } arb_state_t;

    // Per-port starvation counter width (saturates at all-ones).
    localparam int WAIT_W = 8;

    // Bits needed to hold 0..timeout for the ack timeout counter.
    function automatic int tmo_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: lowest-index urgent port, else round-robin
// starting just after the previous grant.
module sdram_arb_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [NUM_PORTS-1:0] urgent,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 valid
);

    logic [NUM_PORTS-1:0] hot;
    logic [IDX_W-1:0]     idx;

    // Urgent ports short-circuit the rotation; x & -x isolates the lowest set bit.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        hot    = eligible & urgent;
        if (|hot) begin
            winner = hot & (~hot + NUM_PORTS'(1));
            valid  = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                idx = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
                if (eligible[idx] && !valid) begin
                    winner[idx] = 1'b1;
                    valid       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Burst-level arbiter sharing one SDRAM controller among NUM_PORTS clients.
// One burst is in flight at a time; the controller ack is steered to the
// granted client only.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 10,
    parameter int MAX_WAIT    = 255,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                        clk_ref,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS-1:0]        port_we,
    input  logic [NUM_PORTS-1:0]        port_urgent,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  port_len,
    output logic [NUM_PORTS-1:0]        port_ack,
    output logic [NUM_PORTS-1:0]        port_grant,
    output logic                        ctl_req,
    output logic                        ctl_we,
    output logic [ADDR_W-1:0]           ctl_addr,
    output logic [LEN_W-1:0]            ctl_len,
    input  logic                        ctl_ack,
    output logic                        err_timeout,
    output logic                        err_spurious
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int TMO_W = tmo_width(ACK_TIMEOUT);

    arb_state_t                          state;
    logic [IDX_W-1:0]                    last_grant;
    logic [IDX_W-1:0]                    win_idx;
    logic [TMO_W-1:0]                    tmo_cnt;
    logic [NUM_PORTS-1:0][WAIT_W-1:0]    wait_cnt;
    logic [NUM_PORTS-1:0]                eligible;
    logic [NUM_PORTS-1:0]                urgent_eff;
    logic [NUM_PORTS-1:0]                winner;
    logic                                win_valid;
    logic                                ack_q;

    // A zero-length burst is never eligible; aged ports count as urgent.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign eligible[i]   = port_req[i] && (port_len[i*LEN_W +: LEN_W] != '0);
        assign urgent_eff[i] = port_urgent[i] || (wait_cnt[i] >= WAIT_W'(MAX_WAIT));
    end

    sdram_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .eligible   (eligible),
        .urgent     (urgent_eff),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_valid)
    );

    // One-hot winner to index for muxing the burst fields.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (winner[i]) win_idx = IDX_W'(i);
    end

    // Ack is combinational so client FIFO strobes line up with the data phase.
    assign port_ack = port_grant & {NUM_PORTS{ctl_ack}};

    // Starvation counters: count while eligible and not being served.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!port_req[i] || (state == ST_ARB && winner[i]))
                    wait_cnt[i] <= '0;
                else if (eligible[i] && !port_grant[i] && wait_cnt[i] != '1)
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
            end
        end
    end

    // Burst FSM with registered controller-side outputs and error pulses.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_grant   <= IDX_W'(NUM_PORTS - 1);
            port_grant   <= '0;
            ctl_req      <= 1'b0;
            ctl_we       <= 1'b0;
            ctl_addr     <= '0;
            ctl_len      <= '0;
            tmo_cnt      <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            ack_q        <= ctl_ack;
            err_timeout  <= 1'b0;
            // An ack edge with no request outstanding is flagged and otherwise ignored.
            err_spurious <= ctl_ack && !ack_q &&
                            (state == ST_IDLE || state == ST_ARB || state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (|eligible) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (win_valid) begin
                        port_grant <= winner;
                        ctl_we     <= port_we[win_idx];
                        ctl_addr   <= port_addr[win_idx*ADDR_W +: ADDR_W];
                        ctl_len    <= port_len[win_idx*LEN_W +: LEN_W];
                        last_grant <= win_idx;
                        tmo_cnt    <= '0;
                        ctl_req    <= 1'b1;
                        state      <= ST_REQ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Count runs 0..ACK_TIMEOUT-1; the abort is the edge it would hit ACK_TIMEOUT.
                    if (ctl_ack) begin
                        ctl_req <= 1'b0;
                        state   <= ST_XFER;
                    end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        ctl_req     <= 1'b0;
                        port_grant  <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_XFER: begin
                    // Grant drops here so a stray ack during DONE reaches no client.
                    if (!ctl_ack) begin
                        port_grant <= '0;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. A second instance with a short
// MAX_WAIT shares all inputs so aging can be contrasted with plain round-robin.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int LW = 10;

    logic              clk_ref = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NP-1:0]     port_req    = '0;
    logic [NP-1:0]     port_we     = '0;
    logic [NP-1:0]     port_urgent = '0;
    logic [NP*AW-1:0]  port_addr   = '0;
    logic [NP*LW-1:0]  port_len    = '0;
    logic              ctl_ack     = 1'b0;

    logic [NP-1:0]     port_ack, port_grant;
    logic              ctl_req, ctl_we, err_timeout, err_spurious;
    logic [AW-1:0]     ctl_addr;
    logic [LW-1:0]     ctl_len;

    logic [NP-1:0]     a_port_ack, a_port_grant;
    logic              a_ctl_req, a_ctl_we, a_err_timeout, a_err_spurious;
    logic [AW-1:0]     a_ctl_addr;
    logic [LW-1:0]     a_ctl_len;

    int checks = 0;
    int errors = 0;

    always #5 clk_ref = ~clk_ref;

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW),
                         .MAX_WAIT(255), .ACK_TIMEOUT(16)) dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .port_req(port_req), .port_we(port_we),
        .port_urgent(port_urgent), .port_addr(port_addr), .port_len(port_len),
        .port_ack(port_ack), .port_grant(port_grant), .ctl_req(ctl_req),
        .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_len(ctl_len), .ctl_ack(ctl_ack),
        .err_timeout(err_timeout), .err_spurious(err_spurious));

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW),
                         .MAX_WAIT(4), .ACK_TIMEOUT(16)) a_dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .port_req(port_req), .port_we(port_we),
        .port_urgent(port_urgent), .port_addr(port_addr), .port_len(port_len),
        .port_ack(a_port_ack), .port_grant(a_port_grant), .ctl_req(a_ctl_req),
        .ctl_we(a_ctl_we), .ctl_addr(a_ctl_addr), .ctl_len(a_ctl_len), .ctl_ack(ctl_ack),
        .err_timeout(a_err_timeout), .err_spurious(a_err_spurious));

    task automatic do_reset();
        rst_n       = 1'b0;
        port_req    = '0;
        port_we     = '0;
        port_urgent = '0;
        port_addr   = '0;
        port_len    = '0;
        ctl_ack     = 1'b0;
        repeat (2) @(negedge clk_ref);
        rst_n = 1'b1;
        @(negedge clk_ref);
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len);
        port_req[p]           = 1'b1;
        port_we[p]            = we;
        port_addr[p*AW +: AW] = addr;
        port_len[p*LW +: LW]  = len;
    endtask

    // Poll at negedges for ctl_req, bounded.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ctl_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_ref);
        end
    endtask

    task automatic serve(input int n);
        ctl_ack = 1'b1;
        repeat (n) @(negedge clk_ref);
        ctl_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        port_req = 4'b1111;
        port_len = {NP{10'd8}};
        ctl_ack  = 1'b0;
        repeat (3) @(negedge clk_ref);
        checks++;
        if ({ctl_req, ctl_we, err_timeout, err_spurious} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 0000", {ctl_req, ctl_we, err_timeout, err_spurious});
        end
        checks++;
        if ({port_grant, port_ack} !== 8'h00) begin
            errors++;
            $display("FAIL reset_grant_ack: got %h exp 00", {port_grant, port_ack});
        end
        checks++;
        if ({ctl_addr, ctl_len} !== '0) begin
            errors++;
            $display("FAIL reset_addr_len: got %h/%h exp 0/0", ctl_addr, ctl_len);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        int bad;
        do_reset();
        set_port(2, 1'b1, 24'h000100, 10'd256);
        @(negedge clk_ref);
        checks++;
        if (ctl_req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_early: got %b exp 0", ctl_req);
        end
        @(negedge clk_ref);
        checks++;
        if (ctl_req !== 1'b1) begin
            errors++;
            $display("FAIL single_req_latency: got %b exp 1", ctl_req);
        end
        checks++;
        if ({ctl_we, ctl_addr, ctl_len, port_grant} !== {1'b1, 24'h000100, 10'd256, 4'b0100}) begin
            errors++;
            $display("FAIL single_fields: got we=%b addr=%h len=%0d g=%b exp 1/000100/256/0100",
                     ctl_we, ctl_addr, ctl_len, port_grant);
        end
        // Client changes after ARB must not disturb the latched burst.
        port_req[2]           = 1'b0;
        port_we[2]            = 1'b0;
        port_addr[2*AW +: AW] = 24'hABCDEF;
        port_len[2*LW +: LW]  = 10'd5;
        bad     = 0;
        ctl_ack = 1'b1;
        repeat (256) begin
            #1;
            if (port_ack !== 4'b0100) bad++;
            @(negedge clk_ref);
        end
        ctl_ack = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL single_port_ack: got %0d bad cycles exp 0", bad);
        end
        checks++;
        if ({ctl_req, ctl_we, ctl_addr, ctl_len} !== {1'b0, 1'b1, 24'h000100, 10'd256}) begin
            errors++;
            $display("FAIL single_latched: got req=%b we=%b addr=%h len=%0d exp 0/1/000100/256",
                     ctl_req, ctl_we, ctl_addr, ctl_len);
        end
        #1;
        checks++;
        if (port_ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack_drop: got %b exp 0000", port_ack);
        end
        @(negedge clk_ref);
        checks++;
        if (port_grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_grant_clear: got %b exp 0000", port_grant);
        end
        repeat (3) @(negedge clk_ref);
    endtask

    task automatic test_round_robin();
        bit ok;
        int bad2;
        logic [NP-1:0] eg;
        logic [AW-1:0] ea;
        do_reset();
        set_port(0, 1'b0, 24'h000010, 10'd4);
        set_port(1, 1'b1, 24'h000020, 10'd4);
        set_port(3, 1'b0, 24'h000030, 10'd4);
        bad2 = 0;
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0:       begin eg = 4'b0001; ea = 24'h000010; end
                1:       begin eg = 4'b0010; ea = 24'h000020; end
                default: begin eg = 4'b1000; ea = 24'h000030; end
            endcase
            wait_req(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_timeout: burst %0d got no ctl_req exp ctl_req", k);
            end
            checks++;
            if ({port_grant, ctl_addr} !== {eg, ea}) begin
                errors++;
                $display("FAIL rr_order: burst %0d got g=%b addr=%h exp g=%b addr=%h",
                         k, port_grant, ctl_addr, eg, ea);
            end
            if (port_grant[2] !== 1'b0) bad2++;
            serve(4);
        end
        checks++;
        if (bad2 !== 0) begin
            errors++;
            $display("FAIL rr_port2: got %0d grants exp 0", bad2);
        end
        port_req = '0;
        repeat (4) @(negedge clk_ref);
    endtask

    // Port 2 is served first so the rotation points at port 3, then ports
    // 1 and 3 compete. early1 raises port 1 during port 2's burst so it ages.
    task automatic scenario(input bit early1, input bit urg1,
                            output logic [NP-1:0] g, output logic [NP-1:0] ag, output bit ok);
        bit ok1;
        do_reset();
        set_port(2, 1'b1, 24'h000200, 10'd4);
        wait_req(ok1);
        if (early1) set_port(1, 1'b0, 24'h000210, 10'd4);
        serve(4);
        port_req[2]    = 1'b0;
        set_port(1, 1'b0, 24'h000210, 10'd4);
        set_port(3, 1'b0, 24'h000230, 10'd4);
        port_urgent[1] = urg1;
        wait_req(ok);
        ok = ok && ok1;
        g  = port_grant;
        ag = a_port_grant;
        serve(4);
        port_req    = '0;
        port_urgent = '0;
        repeat (4) @(negedge clk_ref);
    endtask

    task automatic test_priority();
        logic [NP-1:0] g, ag;
        bit ok;
        scenario(1'b0, 1'b0, g, ag, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin
            errors++;
            $display("FAIL rr_pointer: got ok=%b g=%b exp ok=1 g=1000", ok, g);
        end
        scenario(1'b0, 1'b1, g, ag, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin
            errors++;
            $display("FAIL urgency: got ok=%b g=%b exp ok=1 g=0010", ok, g);
        end
        scenario(1'b1, 1'b0, g, ag, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin
            errors++;
            $display("FAIL no_aging: got ok=%b g=%b exp ok=1 g=1000", ok, g);
        end
        checks++;
        if (ag !== 4'b0010) begin
            errors++;
            $display("FAIL aging: got g=%b exp g=0010", ag);
        end
    endtask

    task automatic test_timeout_spurious();
        bit ok;
        int bad;
        do_reset();
        set_port(0, 1'b1, 24'h000040, 10'd8);
        wait_req(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_req: got no ctl_req exp ctl_req");
        end
        port_req[0] = 1'b0;
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_ref);
            if (k < 16 && (err_timeout !== 1'b0 || ctl_req !== 1'b1)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tmo_early: got %0d bad cycles exp 0", bad);
        end
        checks++;
        if ({err_timeout, ctl_req, port_grant} !== {1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL tmo_abort: got err=%b req=%b g=%b exp 1/0/0000",
                     err_timeout, ctl_req, port_grant);
        end
        @(negedge clk_ref);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse_width: got %b exp 0", err_timeout);
        end
        ctl_ack = 1'b1;
        @(negedge clk_ref);
        checks++;
        if ({err_spurious, port_ack} !== {1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL spurious: got err=%b ack=%b exp 1/0000", err_spurious, port_ack);
        end
        ctl_ack = 1'b0;
        @(negedge clk_ref);
        checks++;
        if ({err_spurious, ctl_req, port_grant} !== {1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL spurious_after: got err=%b req=%b g=%b exp 0/0/0000",
                     err_spurious, ctl_req, port_grant);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        set_port(0, 1'b1, 24'h000050, 10'd8);
        wait_req(ok);
        port_req[0] = 1'b0;
        ctl_ack     = 1'b1;
        repeat (2) @(negedge clk_ref);
        checks++;
        if (!ok || port_ack !== 4'b0001) begin
            errors++;
            $display("FAIL mid_xfer: got ok=%b ack=%b exp ok=1 ack=0001", ok, port_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ctl_req, ctl_we, err_timeout, err_spurious, port_grant, port_ack, ctl_addr, ctl_len} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b we=%b g=%b ack=%b addr=%h len=%0d exp all 0",
                     ctl_req, ctl_we, port_grant, port_ack, ctl_addr, ctl_len);
        end
        ctl_ack = 1'b0;
        @(negedge clk_ref);
        rst_n = 1'b1;
        set_port(0, 1'b0, 24'h000060, 10'd4);
        set_port(1, 1'b0, 24'h000070, 10'd4);
        wait_req(ok);
        checks++;
        if (!ok || port_grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant: got ok=%b g=%b exp ok=1 g=0001", ok, port_grant);
        end
        serve(4);
        port_req = '0;
        repeat (4) @(negedge clk_ref);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_timeout_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
